// File: rtl/bicubic_tap_mac_if.sv
// Valid/ready bus between the bicubic weight stage, the tap MAC and the output buffer.
// Also carries the frame_start pulse and the clamp statistics.
interface bicubic_tap_mac_if #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  p0;
    logic [PIX_W-1:0]  p1;
    logic [PIX_W-1:0]  p2;
    logic [PIX_W-1:0]  p3;
    logic [COEF_W-1:0] w0;
    logic [COEF_W-1:0] w1;
    logic [COEF_W-1:0] w2;
    logic [COEF_W-1:0] w3;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_pix;
    logic              out_last;
    logic              frame_start;
    logic [15:0]       sat_cnt;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, p0, p1, p2, p3, w0, w1, w2, w3, in_last,
        output out_ready, frame_start,
        input  in_ready, out_valid, out_pix, out_last, sat_cnt
    );

    // Tap MAC side
    modport slave (
        input  in_valid, p0, p1, p2, p3, w0, w1, w2, w3, in_last,
        input  out_ready, frame_start,
        output in_ready, out_valid, out_pix, out_last, sat_cnt
    );
endinterface

// File: rtl/bicubic_tap_mac.sv
// Bicubic tap multiply-accumulate: inner taps added, outer taps subtracted,
// rounded, shifted down by FRAC and clamped to the pixel range.
// Four-stage pipeline with a global stall when the output is held.
// Optional clamp-event counter enabled by defining BICUBIC_SAT_CNT_EN.
module bicubic_tap_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 17,
    parameter int FRAC   = 16
) (
    input logic              clk,
    input logic              rst,
    bicubic_tap_mac_if.slave bus
);
    localparam int PW   = PIX_W + COEF_W;  // product width
    localparam int SUMW = PW + 1;          // pos/neg sum width
    localparam int DW   = SUMW + 1;        // signed difference width
    localparam int SW   = DW + 1;          // rounded sum width

    localparam logic signed [SW-1:0] RND     = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [SW-1:0] PIX_MAX = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    logic                     w_en;
    logic [PIX_W-1:0]         w_p    [4];
    logic [COEF_W-1:0]        w_w    [4];
    logic [PW-1:0]            w_prod [4];

    logic                     r_s1_v;
    logic                     r_s1_last;
    logic [PW-1:0]            r_prod [4];

    logic                     r_s2_v;
    logic                     r_s2_last;
    logic [SUMW-1:0]          r_pos;
    logic [SUMW-1:0]          r_neg;

    logic                     r_s3_v;
    logic                     r_s3_last;
    logic signed [SW-1:0]     r_s;

    logic signed [DW-1:0]     w_diff;
    logic signed [SW-1:0]     w_s;
    logic signed [SW-1:0]     w_v;
    logic [PIX_W-1:0]         w_pix;

    logic                     r_out_valid;
    logic                     r_out_last;
    logic [PIX_W-1:0]         r_out_pix;

    // The whole pipeline advances unless the output beat is being held
    assign w_en         = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_en;

    assign w_p[0] = bus.p0;
    assign w_p[1] = bus.p1;
    assign w_p[2] = bus.p2;
    assign w_p[3] = bus.p3;
    assign w_w[0] = bus.w0;
    assign w_w[1] = bus.w1;
    assign w_w[2] = bus.w2;
    assign w_w[3] = bus.w3;

    // Full-width unsigned tap products
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_prod[k] = {{COEF_W{1'b0}}, w_p[k]} * {{PIX_W{1'b0}}, w_w[k]};
        end
    end

    // Stage 1: register products; data only loads on an accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                r_prod[k] <= '0;
            end
        end else if (w_en) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_last <= bus.in_last;
                for (int unsigned k = 0; k < 4; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
        end
    end

    // Stage 2: split into positive (inner) and negative (outer) sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_pos     <= '0;
            r_neg     <= '0;
        end else if (w_en) begin
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
            r_pos     <= {1'b0, r_prod[1]} + {1'b0, r_prod[2]};
            r_neg     <= {1'b0, r_prod[0]} + {1'b0, r_prod[3]};
        end
    end

    // Signed difference plus half-LSB rounding constant
    always_comb begin
        w_diff = $signed({1'b0, r_pos}) - $signed({1'b0, r_neg});
        w_s    = {w_diff[DW-1], w_diff} + RND;
    end

    // Stage 3: register the rounded signed sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_v    <= 1'b0;
            r_s3_last <= 1'b0;
            r_s       <= '0;
        end else if (w_en) begin
            r_s3_v    <= r_s2_v;
            r_s3_last <= r_s2_last;
            r_s       <= w_s;
        end
    end

    // Drop fraction bits and clamp to the pixel range
    always_comb begin
        w_v = r_s >>> FRAC;
        if (w_v[SW-1]) begin
            w_pix = '0;
        end else if (w_v > PIX_MAX) begin
            w_pix = '1;
        end else begin
            w_pix = w_v[PIX_W-1:0];
        end
    end

    // Stage 4: output register, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_pix   <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s3_v;
            if (r_s3_v) begin
                r_out_last <= r_s3_last;
                r_out_pix  <= w_pix;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_pix   = r_out_pix;

`ifdef BICUBIC_SAT_CNT_EN
    logic        w_clamp;
    logic        r_out_clamp;
    logic [15:0] r_sat_cnt;

    assign w_clamp = w_v[SW-1] || (w_v > PIX_MAX);

    // Clamp flag travels with the beat in the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_clamp <= 1'b0;
        end else if (w_en && r_s3_v) begin
            r_out_clamp <= w_clamp;
        end
    end

    // Saturating count of clamped output handshakes; frame_start wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (bus.frame_start) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && bus.out_ready && r_out_clamp && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign bus.sat_cnt = r_sat_cnt;
`else
    assign bus.sat_cnt = '0;
`endif

endmodule

// File: doc/bicubic_tap_mac.md
Name: bicubic_tap_mac

Overview:
- Downstream consumer of the bicubic weight stage.
- Takes four 8-bit neighbour pixels and four unsigned Q1.16 tap-weight magnitudes (the 17-bit weight-stage outputs).
- Forms the bicubic weighted sum: inner taps (1, 2) are added, outer taps (0, 3) are subtracted. Then rounds, clamps to 0..255 and emits one interpolated pixel per accepted beat.
- Sits between the weight pipeline and the line/column output buffer. Uses a valid/ready handshake with full-pipeline stall.

Parameters:
- PIX_W, 8, pixel bit width.
- COEF_W, 17, weight magnitude width; unsigned, 1 integer bit + FRAC fraction bits.
- FRAC, 16, number of fraction bits in the weights.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- p0,p1,p2,p3  input  PIX_W each  neighbour pixels; p0/p3 are the outer taps.
- w0,w1,w2,w3  input  COEF_W each  tap weight magnitudes.
- in_last  input  1  end-of-line sideband; carried with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_pix  output  PIX_W  interpolated, clamped pixel.
- out_last  output  1  delayed in_last.
- frame_start  input  1  one-cycle pulse; clears the statistics counter.
- sat_cnt  output  16  clamp-event count (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits, out_valid, out_pix, out_last and sat_cnt go to 0. In-flight beats are discarded and never emerge after reset release.
- Advance enable: en = !(out_valid && !out_ready). in_ready = en (combinational). A beat is accepted when in_valid && in_ready.
- When en=0, every pipeline register (data and valid) holds.
- Bubbles are carried as valid=0 stages. They do not collapse.
- Stage 1: four products pk*wk, each unsigned, PIX_W+COEF_W = 25 bits, registered. The stage valid bit is loaded with in_valid && in_ready; in_last is registered alongside.
- Stage 2: pos = prod1+prod2, neg = prod0+prod3, each 26 bits unsigned.
- Stage 3: s = pos - neg as a 27-bit signed value, plus rounding constant 2^(FRAC-1). The result is held as a 28-bit signed value.
- Stage 4 (output register): v = s >>> FRAC (arithmetic shift).
  - v < 0 → out_pix = 0.
  - v > 255 → out_pix = 255.
  - otherwise out_pix = v[7:0].
  - out_valid = stage-3 valid; out_last = stage-3 last.
- Latency: 4 clk cycles from acceptance to out_valid when unstalled. Throughput is 1 beat/cycle.
- Ordering: strict FIFO order; no beat is dropped or duplicated under any out_ready pattern.
- out_pix and out_last hold stable while out_valid && !out_ready.
- Weight range: the arithmetic is exact for any COEF_W input. Weights above 1.0 are legal; the clamp handles any overflow.
- in_valid low: no state changes except bubbles advancing while en=1.

Optional Feature:
- Macro: BICUBIC_SAT_CNT_EN.
- Defined:
  - sat_cnt increments by 1 on each output handshake (out_valid && out_ready) whose pixel was clamped, low or high.
  - Saturates at 16'hFFFF.
  - frame_start forces it to 0 on the next edge; frame_start takes priority over a simultaneous increment.
- Undefined: no counter logic is built; sat_cnt is tied to 16'd0.

Test Plan:
- Single tap: w1=65536, all other weights 0, p1=100, out_ready=1 → out_pix=100 exactly 4 cycles after acceptance; out_last follows in_last.
- t=0.5 bicubic weights w0=w3=4096, w1=w2=36864:
  - pixels 100,100,100,100 → 100.
  - pixels 0,255,255,0 → 255 (clamp high; sat_cnt=1 with macro).
  - pixels 255,0,0,255 → 0 (clamp low).
- Rounding: p1=1, w1=32768 → 1. p1=1, w1=32767 → 0.
- Backpressure: stream 8 distinct beats and drop out_ready for 3 cycles mid-stream → in_ready low during the stall, all 8 outputs in order with no duplicates, out_pix stable while stalled.
- Reset mid-stream with 3 beats in flight → out_valid=0 immediately; no stale beat appears after reset release. Bubble pattern in_valid=1,0,1 → outputs separated by one idle cycle.
- With the macro defined: 5 clamping beats, then a frame_start pulse in the same cycle as a sixth clamping handshake → sat_cnt reads 5, then 0.
